// File: rtl/bilinear_interp.sv
// Three-stage valid/ready bilinear interpolator: horizontal lerp, vertical lerp, round-half-up.
// Also counts emitted pixels per frame and pulses done on the last one.
module bilinear_interp #(
    parameter int unsigned PIX_TOTAL = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       p00,
    input  logic [7:0]       p01,
    input  logic [7:0]       p10,
    input  logic [7:0]       p11,
    input  logic [7:0]       fx,
    input  logic [7:0]       fy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_pix,
    output logic [CNT_W-1:0] pix_cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(PIX_TOTAL - 1);

    logic             adv;
    logic             out_xfer;
    logic [8:0]       wx;
    logic [8:0]       wy;
    logic [15:0]      top_d, top_q;
    logic [15:0]      bot_d, bot_q;
    logic [7:0]       fy_q;
    logic             v1_q;
    logic [23:0]      acc_d, acc_q;
    logic             v2_q;
    logic [8:0]       rnd;
    logic [7:0]       pix_d, pix_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        adv      = !(out_valid_q && !out_ready);
        out_xfer = out_valid_q && out_ready;

        // Weights are 1..256 so fx=0 / fy=0 pass the left column / top row through exactly.
        wx    = 9'd256 - {1'b0, fx};
        top_d = 16'(p00) * 16'(wx) + 16'(p01) * 16'(fx);
        bot_d = 16'(p10) * 16'(wx) + 16'(p11) * 16'(fx);

        wy    = 9'd256 - {1'b0, fy_q};
        acc_d = 24'(top_q) * 24'(wy) + 24'(bot_q) * 24'(fy_q);

        // Q8.16 -> integer, round half up; clamp cannot trigger for legal inputs.
        rnd   = 9'((25'(acc_q) + 25'h008000) >> 16);
        pix_d = rnd[8] ? 8'hff : rnd[7:0];

        cnt_d = cnt_q;
        if (out_xfer) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top_q       <= '0;
            bot_q       <= '0;
            fy_q        <= '0;
            v1_q        <= 1'b0;
            acc_q       <= '0;
            v2_q        <= 1'b0;
            pix_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (adv) begin
                top_q       <= top_d;
                bot_q       <= bot_d;
                fy_q        <= fy;
                v1_q        <= in_valid;
                acc_q       <= acc_d;
                v2_q        <= v1_q;
                pix_q       <= pix_d;
                out_valid_q <= v2_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_pix   = pix_q;
    assign pix_cnt   = cnt_q;
    assign done      = out_xfer && (cnt_q == CntLast);

endmodule

// File: tb/tb_bilinear_interp.sv
// Bench for bilinear_interp: directed vectors, backpressure, frame wrap, mid-flight reset
// and a randomized stream checked against a real-arithmetic reference.
module tb_bilinear_interp;

    localparam int unsigned PIX_TOTAL = 4;
    localparam int unsigned CNT_W     = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       p00, p01, p10, p11, fx, fy;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_pix;
    logic [CNT_W-1:0] pix_cnt;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    bilinear_interp #(
        .PIX_TOTAL(PIX_TOTAL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .p00      (p00),
        .p01      (p01),
        .p10      (p10),
        .p11      (p11),
        .fx       (fx),
        .fy       (fy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pix  (out_pix),
        .pix_cnt  (pix_cnt),
        .done     (done)
    );

    // Exact bilinear value via real arithmetic, then round half up and clamp.
    function automatic int ref_pix(int a, int b, int c, int d, int x, int y);
        real top, bot, v;
        int  r;
        top = (a * (256.0 - x) + b * x) / 256.0;
        bot = (c * (256.0 - x) + d * x) / 256.0;
        v   = (top * (256.0 - y) + bot * y) / 256.0;
        r   = int'($floor(v + 0.5));
        if (r > 255) r = 255;
        return r;
    endfunction

    function automatic logic [7:0] rand_frac();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int a, input int b, input int c, input int d,
                           input int x, input int y);
        p00 = 8'(a); p01 = 8'(b); p10 = 8'(c); p11 = 8'(d); fx = 8'(x); fy = 8'(y);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_pix(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        model_cnt = 0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_pix !== 8'd0 || pix_cnt !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b out_pix=%0d pix_cnt=%0d done=%b want 0/0/0/0",
                     out_valid, out_pix, pix_cnt, done);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    // Single sample through an idle pipe; result must appear exactly three cycles later.
    task automatic apply_single(input string name, input int a, input int b, input int c,
                                input int d, input int x, input int y, input int want);
        logic exp_done;
        set_pix(a, b, c, d, x, y);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_early: cycle %0d out_valid=%b in_ready=%b want 0/1",
                         name, k, out_valid, in_ready);
            end
            tick();
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_pix !== 8'(want)) begin
            n_fail++;
            $display("FAIL %s_pix: out_valid=%b out_pix=%0d want 1/%0d",
                     name, out_valid, out_pix, want);
        end
        exp_done = (model_cnt == int'(PIX_TOTAL) - 1);
        n_tests++;
        if (done !== exp_done) begin
            n_fail++;
            $display("FAIL %s_done: got %b want %b", name, done, exp_done);
        end
        tick();
        model_cnt = (model_cnt + 1) % int'(PIX_TOTAL);
        n_tests++;
        if (out_valid !== 1'b0 || pix_cnt !== CNT_W'(model_cnt)) begin
            n_fail++;
            $display("FAIL %s_after: out_valid=%b pix_cnt=%0d want 0/%0d",
                     name, out_valid, pix_cnt, model_cnt);
        end
    endtask

    task automatic test_identity();
        apply_single("identity", 200, 0, 0, 0, 0, 0, 200);
    endtask

    task automatic test_vectors();
        apply_single("half_round", 10, 21, 10, 21, 128, 0, 16);
        apply_single("centre", 0, 0, 0, 255, 128, 128, 64);
        apply_single("near_corner", 0, 0, 0, 255, 255, 255, 253);
        apply_single("max_weights", 0, 255, 255, 255, 255, 255, 255);
    endtask

    task automatic test_backpressure();
        int   sent, got, stalls;
        logic exp_done;
        sent = 0; got = 0; stalls = 0;
        for (int c = 1; c <= 30; c++) begin
            in_valid  = (sent < 6);
            set_pix(sent + 1, 0, 0, 0, 0, 0);
            out_ready = !(c >= 4 && c <= 8);
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                exp_done = (model_cnt == int'(PIX_TOTAL) - 1);
                n_tests++;
                if (out_pix !== 8'(got + 1) || done !== exp_done) begin
                    n_fail++;
                    $display("FAIL bp_order: cycle %0d out_pix=%0d done=%b want %0d/%b",
                             c, out_pix, done, got + 1, exp_done);
                end
                got++;
                model_cnt = (model_cnt + 1) % int'(PIX_TOTAL);
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        n_tests++;
        if (got != 6 || sent != 6 || stalls == 0) begin
            n_fail++;
            $display("FAIL bp_count: got=%0d sent=%0d stalls=%0d want 6/6/>0", got, sent, stalls);
        end
        n_tests++;
        if (pix_cnt !== CNT_W'(model_cnt) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pix_cnt: pix_cnt=%0d out_valid=%b want %0d/0",
                     pix_cnt, out_valid, model_cnt);
        end
    endtask

    task automatic test_frame();
        int   exp_q[$];
        int   sent, pulses;
        logic xfer, exp_done;
        do_reset();
        sent = 0; pulses = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (sent < 5);
            set_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), rand_frac(), rand_frac());
            #1;
            xfer     = out_valid && out_ready;
            exp_done = xfer && (model_cnt == int'(PIX_TOTAL) - 1);
            n_tests++;
            if (done !== exp_done || pix_cnt !== CNT_W'(model_cnt)) begin
                n_fail++;
                $display("FAIL frame_done: cycle %0d done=%b pix_cnt=%0d want %b/%0d",
                         c, done, pix_cnt, exp_done, model_cnt);
            end
            if (done === 1'b1) pulses++;
            if (xfer) begin
                n_tests++;
                if (exp_q.size() == 0 || out_pix !== 8'(exp_q[0])) begin
                    n_fail++;
                    $display("FAIL frame_pix: cycle %0d out_pix=%0d want %0d", c, out_pix,
                             (exp_q.size() == 0) ? -1 : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                model_cnt = (model_cnt + 1) % int'(PIX_TOTAL);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_pix(p00, p01, p10, p11, fx, fy));
                sent++;
            end
            tick();
        end
        n_tests++;
        if (pulses != 1 || pix_cnt !== CNT_W'(1) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL frame_end: pulses=%0d pix_cnt=%0d left=%0d want 1/1/0",
                     pulses, pix_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_pix(90, 90, 90, 90, 0, 0);
        tick();
        tick();
        // Reset lands together with a third offered sample; all of it must vanish.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        model_cnt = 0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || pix_cnt !== '0 || out_pix !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_state: out_valid=%b pix_cnt=%0d out_pix=%0d want 0/0/0",
                     out_valid, pix_cnt, out_pix);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0 || pix_cnt !== '0) begin
                n_fail++;
                $display("FAIL midreset_stale: cycle %0d out_valid=%b pix_cnt=%0d want 0/0",
                         c, out_valid, pix_cnt);
            end
        end
    endtask

    task automatic test_random();
        int   exp_q[$];
        logic xfer, exp_done;
        int   drain;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), rand_frac(), rand_frac());
            #1;
            xfer     = out_valid && out_ready;
            exp_done = xfer && (model_cnt == int'(PIX_TOTAL) - 1);
            n_tests++;
            if (done !== exp_done || pix_cnt !== CNT_W'(model_cnt)
                || in_ready !== !(out_valid && !out_ready)) begin
                n_fail++;
                $display("FAIL rand_ctrl: cycle %0d done=%b pix_cnt=%0d in_ready=%b want %b/%0d",
                         c, done, pix_cnt, in_ready, exp_done, model_cnt);
            end
            if (xfer) begin
                n_tests++;
                if (exp_q.size() == 0 || out_pix !== 8'(exp_q[0])) begin
                    n_fail++;
                    $display("FAIL rand_pix: cycle %0d out_pix=%0d want %0d", c, out_pix,
                             (exp_q.size() == 0) ? -1 : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                model_cnt = (model_cnt + 1) % int'(PIX_TOTAL);
            end
            if (in_valid && in_ready) exp_q.push_back(ref_pix(p00, p01, p10, p11, fx, fy));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain = 0;
        while ((exp_q.size() != 0 || out_valid) && drain < 20) begin
            #1;
            if (out_valid) begin
                n_tests++;
                if (exp_q.size() == 0 || out_pix !== 8'(exp_q[0])) begin
                    n_fail++;
                    $display("FAIL rand_drain: out_pix=%0d want %0d", out_pix,
                             (exp_q.size() == 0) ? -1 : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                model_cnt = (model_cnt + 1) % int'(PIX_TOTAL);
            end
            tick();
            drain++;
        end
        n_tests++;
        if (exp_q.size() != 0 || pix_cnt !== CNT_W'(model_cnt)) begin
            n_fail++;
            $display("FAIL rand_end: left=%0d pix_cnt=%0d want 0/%0d",
                     exp_q.size(), pix_cnt, model_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_vectors();
        test_backpressure();
        test_frame();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
